// File: rtl/rl_fifo_pkg.sv
// rtl/rl_fifo_pkg.sv - shared constants for the RAM-backed FIFO controller
package rl_fifo_pkg;

    localparam int OUTBUF_DEPTH = 2;
    localparam int OCC_W        = $clog2(OUTBUF_DEPTH + 1);

endpackage

// File: rtl/rl_fifo_outbuf.sv
// rtl/rl_fifo_outbuf.sv - 2-entry show-ahead output buffer fed by RAM read data
module rl_fifo_outbuf
    import rl_fifo_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             cap_i,
    input  logic [DBITS-1:0] cap_data_i,
    input  logic             pop_i,
    output logic [OCC_W-1:0] occ_o,
    output logic [DBITS-1:0] head_o
);

    logic [OCC_W-1:0] occ_q, occ_d, occ_s;
    logic [DBITS-1:0] slot0_q, slot0_d, slot1_q, slot1_d;

    // Shift on pop first, then place the captured word behind whatever remains.
    always_comb begin
        occ_s   = occ_q - OCC_W'(pop_i);
        slot0_d = pop_i ? slot1_q : slot0_q;
        slot1_d = slot1_q;
        if (cap_i) begin
            if (occ_s == '0) begin
                slot0_d = cap_data_i;
            end else begin
                slot1_d = cap_data_i;
            end
        end
        occ_d = occ_s + OCC_W'(cap_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    assign occ_o  = occ_q;
    assign head_o = slot0_q;

endmodule

// File: rtl/rl_fifo_1r1w_ctrl.sv
// rtl/rl_fifo_1r1w_ctrl.sv - FIFO controller sequencing an external 1R1W RAM with prefetch
module rl_fifo_1r1w_ctrl
    import rl_fifo_pkg::*;
#(
    parameter int ABITS    = 10,
    parameter int DBITS    = 32,
    parameter int AFULL_TH = 2**ABITS - 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [DBITS-1:0]       din_i,
    output logic                   full_o,
    output logic                   almost_full_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [DBITS-1:0]       dout_o,
    output logic [ABITS+1:0]       count_o,
    output logic                   overflow_o,
    output logic [ABITS-1:0]       ram_waddr_o,
    output logic [DBITS-1:0]       ram_din_o,
    output logic                   ram_we_o,
    output logic [(DBITS+7)/8-1:0] ram_be_o,
    output logic [ABITS-1:0]       ram_raddr_o,
    output logic                   ram_re_o,
    input  logic [DBITS-1:0]       ram_dout_i
);

    localparam int DEPTH = 2**ABITS;

    typedef logic [ABITS-1:0] ptr_t;
    typedef logic [ABITS:0]   cnt_t;

    ptr_t             wptr_q, rptr_q;
    cnt_t             ramcnt_q, ramcnt_d;
    logic             inflight_q;
    logic [ABITS+1:0] count_q, count_d;
    logic             full_q, afull_q, ovf_q;
    logic [OCC_W-1:0] bufocc;
    logic [DBITS-1:0] head;
    logic             pop, wr, re;
    logic [2:0]       slots_used;

    assign pop = (bufocc != '0) && ready_i;
    assign wr  = push_i && !full_q && !flush_i;

    // Slots still claimed after this cycle's pop; a new read may be issued only if one is free.
    assign slots_used = 3'(bufocc) + 3'(inflight_q) - 3'(pop);
    assign re         = (ramcnt_q != '0) && (slots_used < 3'd2);

    assign ramcnt_d = ramcnt_q + cnt_t'(wr) - cnt_t'(re);
    assign count_d  = count_q + (ABITS+2)'(wr) - (ABITS+2)'(pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ramcnt_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (wr) wptr_q <= wptr_q + 1'b1;
            if (re) rptr_q <= rptr_q + 1'b1;
            ramcnt_q   <= ramcnt_d;
            inflight_q <= re;
            count_q    <= count_d;
            full_q     <= (ramcnt_d == cnt_t'(DEPTH));
            afull_q    <= (ramcnt_d >= cnt_t'(AFULL_TH));
            ovf_q      <= push_i && full_q;
        end
    end

    rl_fifo_outbuf #(
        .DBITS (DBITS)
    ) u_outbuf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .cap_i      (inflight_q),
        .cap_data_i (ram_dout_i),
        .pop_i      (pop),
        .occ_o      (bufocc),
        .head_o     (head)
    );

    assign full_o        = full_q;
    assign almost_full_o = afull_q;
    assign valid_o       = (bufocc != '0);
    assign dout_o        = head;
    assign count_o       = count_q;
    assign overflow_o    = ovf_q;
    assign ram_we_o      = wr;
    assign ram_waddr_o   = wptr_q;
    assign ram_din_o     = din_i;
    assign ram_be_o      = '1;
    assign ram_re_o      = re;
    assign ram_raddr_o   = rptr_q;

endmodule
